// File: rtl/rom_arb_pkg.sv
// Shared types and default widths for the ROM burst arbiter.
package rom_arb_pkg;

  localparam int unsigned NUM_REQ_DEF = 4;
  localparam int unsigned ADDR_W_DEF  = 3;
  localparam int unsigned DATA_W_DEF  = 8;
  localparam int unsigned LEN_W_DEF   = 3;

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } arb_state_e;

  // Width of an index into n requesters, never below one bit.
  function automatic int unsigned idx_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rom_arbiter_if.sv
// Requester-side and ROM-side bus of the ROM burst arbiter.
interface rom_arbiter_if
  import rom_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ = NUM_REQ_DEF,
  parameter int unsigned ADDR_W  = ADDR_W_DEF,
  parameter int unsigned DATA_W  = DATA_W_DEF,
  parameter int unsigned LEN_W   = LEN_W_DEF
) ();

  logic [NUM_REQ-1:0]        req;
  logic [NUM_REQ*ADDR_W-1:0] req_addr;
  logic [NUM_REQ*LEN_W-1:0]  req_len;
  logic [NUM_REQ-1:0]        gnt;
  logic [NUM_REQ-1:0]        rvalid;
  logic                      rlast;
  logic [DATA_W-1:0]         rdata;
  logic                      busy;
  logic                      rom_enb;
  logic [ADDR_W-1:0]         rom_addr;
  logic [DATA_W-1:0]         rom_out;

  modport master (
    input  req, req_addr, req_len, rom_out,
    output gnt, rvalid, rlast, rdata, busy, rom_enb, rom_addr
  );

  modport slave (
    output req, req_addr, req_len, rom_out,
    input  gnt, rvalid, rlast, rdata, busy, rom_enb, rom_addr
  );

endinterface

// File: rtl/rom_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request at or above ptr, with wrap.
module rr_pick
  import rom_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ = NUM_REQ_DEF,
  localparam int unsigned PTR_W  = idx_w(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [PTR_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] win,
  output logic [PTR_W-1:0]   win_idx
);

  logic [2*NUM_REQ-1:0] dbl;
  logic [NUM_REQ-1:0]   rot;
  logic [NUM_REQ-1:0]   lowest;
  logic [PTR_W:0]       pos;
  logic [PTR_W:0]       sum;
  logic [PTR_W-1:0]     off;

  always_comb begin
    dbl    = {req, req};
    rot    = '0;
    pos    = '0;
    off    = '0;
    // Rotating through the doubled vector puts ptr at bit 0, so wrap is free.
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      pos    = {1'b0, ptr} + (PTR_W + 1)'(i);
      rot[i] = dbl[pos];
    end
    lowest = rot & (~rot + NUM_REQ'(1));
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (lowest[i]) off = PTR_W'(i);
    end
    sum = {1'b0, ptr} + {1'b0, off};
    if (sum >= (PTR_W + 1)'(NUM_REQ)) sum = sum - (PTR_W + 1)'(NUM_REQ);
    win_idx = sum[PTR_W-1:0];
    win     = (|rot) ? (NUM_REQ'(1) << win_idx) : '0;
  end

endmodule

// File: rtl/rom_arbiter.sv
// Round-robin burst arbiter in front of a single-port registered-read ROM.
module rom_arbiter
  import rom_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ = NUM_REQ_DEF,
  parameter int unsigned ADDR_W  = ADDR_W_DEF,
  parameter int unsigned DATA_W  = DATA_W_DEF,
  parameter int unsigned LEN_W   = LEN_W_DEF
) (
  input logic           clk,
  input logic           rst,
  rom_arbiter_if.master bus
);

  localparam int unsigned PTR_W = idx_w(NUM_REQ);

  arb_state_e         state_q, state_d;
  logic [PTR_W-1:0]   ptr_q, ptr_d;
  logic [ADDR_W-1:0]  cur_addr_q, cur_addr_d;
  logic [LEN_W-1:0]   beats_q, beats_d;
  logic [NUM_REQ-1:0] owner_q, owner_d;
  logic               first_q, first_d;
  logic               tag_valid_q, tag_valid_d;
  logic [NUM_REQ-1:0] tag_owner_q, tag_owner_d;
  logic               tag_last_q, tag_last_d;

  logic [NUM_REQ-1:0] win;
  logic [PTR_W-1:0]   win_idx;
  logic [ADDR_W-1:0]  sel_addr;
  logic [LEN_W-1:0]   sel_len;
  logic [DATA_W-1:0]  rdata_w;

  rr_pick #(.NUM_REQ(NUM_REQ)) u_rr_pick (
    .req     (bus.req),
    .ptr     (ptr_q),
    .win     (win),
    .win_idx (win_idx)
  );

  always_comb begin : select
    sel_addr = '0;
    sel_len  = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      if (win[k]) begin
        sel_addr = bus.req_addr[k*ADDR_W +: ADDR_W];
        sel_len  = bus.req_len[k*LEN_W +: LEN_W];
      end
    end
  end

  always_comb begin : next_state
    state_d    = state_q;
    ptr_d      = ptr_q;
    cur_addr_d = cur_addr_q;
    beats_d    = beats_q;
    owner_d    = owner_q;
    first_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (|bus.req) begin
          cur_addr_d = sel_addr;
          beats_d    = sel_len;
          owner_d    = win;
          first_d    = 1'b1;
          ptr_d      = (win_idx == PTR_W'(NUM_REQ - 1)) ? '0 : win_idx + 1'b1;
          state_d    = BURST;
        end
      end
      BURST: begin
        cur_addr_d = cur_addr_q + 1'b1;
        beats_d    = beats_q - 1'b1;
        if (beats_q == '0) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Tag follows the beat the ROM samples at this edge.
    tag_valid_d = (state_q == BURST);
    tag_owner_d = (state_q == BURST) ? owner_q : '0;
    tag_last_d  = (state_q == BURST) && (beats_q == '0);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      ptr_q       <= '0;
      cur_addr_q  <= '0;
      beats_q     <= '0;
      owner_q     <= '0;
      first_q     <= 1'b0;
      tag_valid_q <= 1'b0;
      tag_owner_q <= '0;
      tag_last_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      cur_addr_q  <= cur_addr_d;
      beats_q     <= beats_d;
      owner_q     <= owner_d;
      first_q     <= first_d;
      tag_valid_q <= tag_valid_d;
      tag_owner_q <= tag_owner_d;
      tag_last_q  <= tag_last_d;
    end
  end

  always_comb begin : outputs
    rdata_w      = tag_valid_q ? bus.rom_out : '0;
    bus.busy     = (state_q == BURST);
    bus.rom_enb  = (state_q == BURST);
    bus.rom_addr = (state_q == BURST) ? cur_addr_q : '0;
    bus.gnt      = first_q ? owner_q : '0;
    bus.rvalid   = tag_valid_q ? tag_owner_q : '0;
    bus.rlast    = tag_valid_q & tag_last_q;
    bus.rdata    = rdata_w;
  end

  rvalid_onehot: assert property (@(posedge clk) disable iff (rst) $onehot0(bus.rvalid));
  gnt_onehot:    assert property (@(posedge clk) disable iff (rst) $onehot0(bus.gnt));

endmodule
